// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory-interface unit: holds address and data registers between the bus and RAM,
// and sequences read/write cycles in fixed-latency or ack-with-timeout mode.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int ACK_MODE   = 0,
    parameter int MEM_LAT    = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  mar_in,
    input  logic                  mdr_in,
    input  logic                  rd_req,
    input  logic                  wr_req,
    output logic [DATA_WIDTH-1:0] mdr_q,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [7:0] LAT_LAST = 8'(MEM_LAT - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    op_wr_r;
    logic                    op_next_s;
    logic [7:0]              cnt_r;
    logic [7:0]              cnt_next_s;
    logic [ADDR_WIDTH-1:0]   mar_r;
    logic [DATA_WIDTH-1:0]   mdr_r;
    logic                    complete_s;
    logic                    timeout_s;
    logic                    mem_cs_r;
    logic                    mem_we_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;

    // Access termination: fixed count in latency mode, ack or timeout in ack mode.
    always_comb begin
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        if (ACK_MODE == 32'sd0) begin
            complete_s = (cnt_r == LAT_LAST);
            timeout_s  = 1'b0;
        end else begin
            complete_s = mem_ack;
            timeout_s  = (cnt_r == TO_LAST) && !mem_ack;
        end
    end

    // Next-state, latched operation and access-cycle counter.
    always_comb begin
        next_state_s = state_r;
        op_next_s    = op_wr_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (rd_req ^ wr_req) begin
                    next_state_s = S_ACCESS;
                    op_next_s    = wr_req;
                    cnt_next_s   = 8'd0;
                end else if (rd_req & wr_req) begin
                    next_state_s = S_ERR;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (complete_s) begin
                    next_state_s = S_DONE;
                end else if (timeout_s) begin
                    next_state_s = S_ERR;
                end else begin
                    next_state_s = S_ACCESS;
                    cnt_next_s   = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            S_ERR:   next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= S_IDLE;
            op_wr_r <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= next_state_s;
            op_wr_r <= op_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Outputs are registered from the next state so they line up with the state they decode.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mem_cs_r <= 1'b0;
            mem_we_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            mem_cs_r <= (next_state_s == S_ACCESS);
            mem_we_r <= (next_state_s == S_ACCESS) && op_next_s;
            busy_r   <= (next_state_s == S_ACCESS) || (next_state_s == S_DONE);
            done_r   <= (next_state_s == S_DONE) || (next_state_s == S_ERR);
            err_r    <= (next_state_s == S_ERR);
        end
    end

    // MAR/MDR: bus loads only in IDLE; read data captured on the completing edge.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mar_r <= {ADDR_WIDTH{1'b0}};
            mdr_r <= {DATA_WIDTH{1'b0}};
        end else if (state_r == S_IDLE) begin
            if (mar_in) begin
                mar_r <= bus_in[ADDR_WIDTH-1:0];
            end
            if (mdr_in) begin
                mdr_r <= bus_in;
            end
        end else if ((state_r == S_ACCESS) && complete_s && !op_wr_r) begin
            mdr_r <= mem_rdata;
        end
    end

    assign mdr_q     = mdr_r;
    assign mem_wdata = mdr_r;
    assign mem_addr  = mar_r;
    assign mem_cs    = mem_cs_r;
    assign mem_we    = mem_we_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
